// File: rtl/mux_scan_ctrl_if.sv
// Scan-controller bus: select/handshake/capture signals between the scanner and the 16-to-1 mux.
// Latency: none (wires only).
// Backpressure: none; start is a level request sampled only when the scanner is idle.
// Optional parity output exists only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if;
   logic        start;
   logic        abort;
   logic        f;
   logic [3:0]  S16;
   logic        busy;
   logic        done;
   logic [0:15] result;
`ifdef MUX_SCAN_PARITY_EN
   logic        parity;

   modport master (input start, abort, f, output S16, busy, done, result, parity);
   modport slave  (output start, abort, f, input S16, busy, done, result, parity);
`else
   modport master (input start, abort, f, output S16, busy, done, result);
   modport slave  (output start, abort, f, input S16, busy, done, result);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through channels 0..15, holds each SETTLE_CYCLES clocks, captures f into result[S16].
// Latency: a full scan takes 16*SETTLE_CYCLES edges after the start edge, then done pulses for one cycle.
// Backpressure: start is ignored while busy or in DONE (no queuing); abort returns to IDLE on the next edge.
// Optional MUX_SCAN_PARITY_EN adds a registered XOR of result, updated together with done.
module mux_scan_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   mux_scan_ctrl_if.master bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q,  state_d;
   logic [3:0]       sel_q,    sel_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [0:15]      result_q, result_d;

   // Next-state logic: idle/settle/done sequencing, per-channel capture and abort handling
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            // abort wins over a simultaneous start
            if (bus.start && !bus.abort) begin
               state_d = ST_SETTLE;
               sel_d   = 4'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (bus.abort) begin
               // captured bits are kept, remaining bits untouched
               state_d = ST_IDLE;
               sel_d   = 4'd0;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               result_d[sel_q] = bus.f;
               cnt_d           = '0;
               if (sel_q == 4'd15) begin
                  // select stays on 15 through the DONE cycle
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  sel_d = sel_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            sel_d   = 4'd0;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = 4'd0;
            cnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= 4'd0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

`ifdef MUX_SCAN_PARITY_EN
   logic parity_q, parity_d;

   // Parity refreshes only on the edge that enters DONE, so aborts leave it alone
   always_comb begin
      parity_d = parity_q;
      if (state_q == ST_SETTLE && state_d == ST_DONE) begin
         parity_d = ^result_d;
      end
   end

   // Parity register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign bus.parity = parity_q;
`endif

   assign bus.S16    = sel_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule
